burst_ram_arbiter: RTL and testbench

//  Shares one burst RAM controller port between two burst masters (port 0: instruction cache, port 1: data cache).

---
 rtl/burst_ram_arbiter.sv | 136 +++++++++++++
 tb/tb_burst_ram_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram_arbiter.sv
// Two-port burst arbiter in front of a single burst RAM controller: grants whole bursts,
// forwards the owner's command/data and steers read-ready back to it. Macro: BURST_ARBITER_ROUND_ROBIN_EN.
module burst_ram_arbiter #(
    parameter int BURST_RAM_DEPTH_BITWIDTH = 4,
    parameter int BURST_LENGTH             = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                p0_cmd,
    input  logic                                p0_cmd_en,
    input  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] p0_addr,
    input  logic [63:0]                         p0_wr_data,
    input  logic [7:0]                          p0_data_mask,
    output logic                                p0_grant,
    output logic [63:0]                         p0_rd_data,
    output logic                                p0_rd_data_ready,
    output logic                                p0_busy,
    input  logic                                p1_cmd,
    input  logic                                p1_cmd_en,
    input  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] p1_addr,
    input  logic [63:0]                         p1_wr_data,
    input  logic [7:0]                          p1_data_mask,
    output logic                                p1_grant,
    output logic [63:0]                         p1_rd_data,
    output logic                                p1_rd_data_ready,
    output logic                                p1_busy,
    output logic                                br_cmd,
    output logic                                br_cmd_en,
    output logic [BURST_RAM_DEPTH_BITWIDTH-1:0] br_addr,
    output logic [63:0]                         br_wr_data,
    output logic [7:0]                          br_data_mask,
    input  logic [63:0]                         br_rd_data,
    input  logic                                br_rd_data_ready,
    input  logic                                br_busy
);

    localparam int CW = (BURST_LENGTH > 2) ? $clog2(BURST_LENGTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_BEATS,
        READ_BEATS
    } state_t;

    state_t          state, state_next;
    logic            owner, owner_next;
    logic            last_grant, last_grant_next;
    logic [CW-1:0]   beat_cnt, beat_cnt_next;
    logic            winner;
    logic            grant;
    logic            sel;

`ifdef BURST_ARBITER_ROUND_ROBIN_EN
    assign winner = (p0_cmd_en && p1_cmd_en) ? ~last_grant : p1_cmd_en;
`else
    assign winner = ~p0_cmd_en;
`endif

    assign grant = !rst && (state == IDLE) && !br_busy && (p0_cmd_en || p1_cmd_en);
    assign sel   = (state == IDLE) ? winner : owner;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        p0_grant         = 1'b0;
        p1_grant         = 1'b0;
        p0_rd_data_ready = 1'b0;
        p1_rd_data_ready = 1'b0;
        p0_busy          = 1'b0;
        p1_busy          = 1'b0;
        p0_rd_data       = br_rd_data;
        p1_rd_data       = br_rd_data;
        br_cmd           = 1'b0;
        br_cmd_en        = 1'b0;
        br_addr          = '0;
        br_wr_data       = '0;
        br_data_mask     = '0;
        if (!rst) begin
            br_cmd       = sel ? p1_cmd       : p0_cmd;
            br_addr      = sel ? p1_addr      : p0_addr;
            br_wr_data   = sel ? p1_wr_data   : p0_wr_data;
            br_data_mask = sel ? p1_data_mask : p0_data_mask;
            br_cmd_en    = grant;
            p0_grant     = grant && !winner;
            p1_grant     = grant && winner;
            p0_rd_data_ready = (state == READ_BEATS) && !owner && br_rd_data_ready;
            p1_rd_data_ready = (state == READ_BEATS) &&  owner && br_rd_data_ready;
            p0_busy      = (state != IDLE) &&  owner;
            p1_busy      = (state != IDLE) && !owner;
        end
    end

    always_comb begin
        state_next      = state;
        owner_next      = owner;
        last_grant_next = last_grant;
        beat_cnt_next   = beat_cnt;
        case (state)
            IDLE: begin
                if (grant) begin
                    owner_next      = winner;
                    last_grant_next = winner;
                    beat_cnt_next   = CW'(1);
                    state_next      = br_cmd ? WRITE_BEATS : READ_BEATS;
                end
            end
            WRITE_BEATS: begin
                beat_cnt_next = beat_cnt + CW'(1);
                if (beat_cnt == CW'(BURST_LENGTH - 1)) state_next = IDLE;
            end
            READ_BEATS: begin
                // Counter starts at 1 on grant, so the last ready beat is the one seen at wrap (0).
                if (br_rd_data_ready) begin
                    beat_cnt_next = beat_cnt + CW'(1);
                    if (beat_cnt == '0) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last_grant <= last_grant_next;
            beat_cnt   <= beat_cnt_next;
        end
    end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed scoreboard bench for burst_ram_arbiter; expectations for simultaneous requests
// follow BURST_ARBITER_ROUND_ROBIN_EN the same way the design build does.
module tb_burst_ram_arbiter;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_cmd, p0_cmd_en, p1_cmd, p1_cmd_en;
    logic [DW-1:0] p0_addr, p1_addr, br_addr;
    logic [63:0]   p0_wr_data, p1_wr_data, br_wr_data;
    logic [7:0]    p0_data_mask, p1_data_mask, br_data_mask;
    logic          p0_grant, p1_grant, p0_rd_data_ready, p1_rd_data_ready, p0_busy, p1_busy;
    logic [63:0]   p0_rd_data, p1_rd_data, br_rd_data;
    logic          br_cmd, br_cmd_en, br_rd_data_ready, br_busy;

    typedef struct {
        logic          cmd;
        logic [DW-1:0] addr;
        logic          port;
    } cmd_exp_t;

    typedef struct {
        logic        port;
        logic [63:0] data;
    } rd_exp_t;

    cmd_exp_t cmd_q[$];
    rd_exp_t  rd_q[$];
    int       checks   = 0;
    int       failures = 0;

    burst_ram_arbiter #(.BURST_RAM_DEPTH_BITWIDTH(DW), .BURST_LENGTH(4)) dut (
        .clk(clk), .rst(rst),
        .p0_cmd(p0_cmd), .p0_cmd_en(p0_cmd_en), .p0_addr(p0_addr), .p0_wr_data(p0_wr_data),
        .p0_data_mask(p0_data_mask), .p0_grant(p0_grant), .p0_rd_data(p0_rd_data),
        .p0_rd_data_ready(p0_rd_data_ready), .p0_busy(p0_busy),
        .p1_cmd(p1_cmd), .p1_cmd_en(p1_cmd_en), .p1_addr(p1_addr), .p1_wr_data(p1_wr_data),
        .p1_data_mask(p1_data_mask), .p1_grant(p1_grant), .p1_rd_data(p1_rd_data),
        .p1_rd_data_ready(p1_rd_data_ready), .p1_busy(p1_busy),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
        .br_data_mask(br_data_mask), .br_rd_data(br_rd_data),
        .br_rd_data_ready(br_rd_data_ready), .br_busy(br_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pops the scoreboard whenever the DUT issues a command or forwards a read beat.
    task automatic monitor();
        cmd_exp_t c;
        rd_exp_t  r;
        if (br_cmd_en) begin
            if (cmd_q.size() == 0) check("cmd_unexpected", 64'(br_cmd_en), 64'(0));
            else begin
                c = cmd_q.pop_front();
                check("cmd_grant", 64'({p1_grant, p0_grant}), c.port ? 64'(2) : 64'(1));
                check("cmd_type", 64'(br_cmd), 64'(c.cmd));
                check("cmd_addr", 64'(br_addr), 64'(c.addr));
            end
        end
        if (p0_rd_data_ready || p1_rd_data_ready) begin
            if (rd_q.size() == 0) check("rd_unexpected", 64'({p1_rd_data_ready, p0_rd_data_ready}), 64'(0));
            else begin
                r = rd_q.pop_front();
                check("rd_port", 64'({p1_rd_data_ready, p0_rd_data_ready}), r.port ? 64'(2) : 64'(1));
                check("rd_data", r.port ? p1_rd_data : p0_rd_data, r.data);
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic expect_cmd(input logic cmd, input logic [DW-1:0] addr, input logic port);
        cmd_exp_t c;
        c.cmd = cmd; c.addr = addr; c.port = port;
        cmd_q.push_back(c);
    endtask

    task automatic read_beats(input logic port, input int n, input logic [63:0] base);
        rd_exp_t r;
        for (int i = 0; i < n; i++) begin
            br_rd_data_ready = 1'b1;
            br_rd_data       = base + 64'(i);
            r.port = port; r.data = br_rd_data;
            rd_q.push_back(r);
            tick();
        end
        br_rd_data_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; br_busy = 1'b0; br_rd_data_ready = 1'b0; br_rd_data = '0;
        p0_cmd = 1'b0; p0_cmd_en = 1'b0; p0_addr = '0; p0_wr_data = '0; p0_data_mask = '0;
        p1_cmd = 1'b0; p1_cmd_en = 1'b0; p1_addr = '0; p1_wr_data = '0; p1_data_mask = '0;
        tick();

        // Reset: requests and ready ignored, read data still broadcast.
        p0_cmd_en = 1'b1; p0_addr = 4'd7; br_rd_data_ready = 1'b1; br_rd_data = 64'h1234;
        settle();
        check("rst_grant", 64'(p0_grant), 64'(0));
        check("rst_cmd_en", 64'(br_cmd_en), 64'(0));
        check("rst_addr", 64'(br_addr), 64'(0));
        check("rst_ready", 64'(p0_rd_data_ready), 64'(0));
        check("rst_rd_data0", p0_rd_data, 64'h1234);
        check("rst_rd_data1", p1_rd_data, 64'h1234);
        advance();
        rst = 1'b0; p0_cmd_en = 1'b0; br_rd_data_ready = 1'b0;
        tick();

        // Port 0 read at address 4.
        p0_cmd = 1'b0; p0_addr = 4'd4; p0_cmd_en = 1'b1;
        expect_cmd(1'b0, 4'd4, 1'b0);
        settle();
        check("t1_p0_grant", 64'(p0_grant), 64'(1));
        advance();
        p0_cmd_en = 1'b0;
        settle();
        check("t1_p1_busy", 64'(p1_busy), 64'(1));
        check("t1_p0_busy", 64'(p0_busy), 64'(0));
        advance();
        read_beats(1'b0, 2, 64'hD000);
        tick();                                   // gap cycle without ready
        read_beats(1'b0, 2, 64'hD002);
        br_rd_data_ready = 1'b1;                  // stray beat in IDLE
        settle();
        check("t1_idle_busy", 64'(p1_busy), 64'(0));
        check("t1_stray_ready", 64'({p1_rd_data_ready, p0_rd_data_ready}), 64'(0));
        advance();
        br_rd_data_ready = 1'b0;

        // Port 1 write at address 8, beats A0..A3.
        p1_cmd = 1'b1; p1_addr = 4'd8; p1_cmd_en = 1'b1; p1_wr_data = 64'hA0; p1_data_mask = 8'hF0;
        p0_wr_data = 64'hBAD;
        expect_cmd(1'b1, 4'd8, 1'b1);
        settle();
        check("t2_wr_beat0", br_wr_data, 64'hA0);
        check("t2_mask", 64'(br_data_mask), 64'hF0);
        advance();
        p1_cmd_en = 1'b0;
        for (int k = 1; k < 4; k++) begin
            p1_wr_data = 64'hA0 + 64'(k);
            br_rd_data_ready = (k == 2);
            settle();
            check("t2_wr_beat", br_wr_data, 64'hA0 + 64'(k));
            check("t2_p0_busy", 64'(p0_busy), 64'(1));
            advance();
        end
        br_rd_data_ready = 1'b0;
        p0_cmd = 1'b0; p0_addr = 4'd2; p0_cmd_en = 1'b1;   // grant in first IDLE cycle
        expect_cmd(1'b0, 4'd2, 1'b0);
        settle();
        check("t2_b2b_grant", 64'(p0_grant), 64'(1));
        advance();
        p0_cmd_en = 1'b0;
        read_beats(1'b0, 4, 64'hE000);

        // Simultaneous reads after reset; port 0 keeps requesting.
        rst = 1'b1; tick(); rst = 1'b0;
        p0_cmd = 1'b0; p0_addr = 4'd1; p0_cmd_en = 1'b1;
        p1_cmd = 1'b0; p1_addr = 4'd3; p1_cmd_en = 1'b1;
        expect_cmd(1'b0, 4'd1, 1'b0);
        settle();
        check("t3_first_p0", 64'({p1_grant, p0_grant}), 64'(1));
        advance();
        settle();
        check("t3_p1_busy", 64'(p1_busy), 64'(1));
        advance();
        read_beats(1'b0, 4, 64'hF000);
`ifdef BURST_ARBITER_ROUND_ROBIN_EN
        expect_cmd(1'b0, 4'd3, 1'b1);
        settle();
        check("t3_rr_p1", 64'({p1_grant, p0_grant}), 64'(2));
        advance();
        p1_cmd_en = 1'b0;
        read_beats(1'b1, 4, 64'hF100);
        expect_cmd(1'b0, 4'd1, 1'b0);
        settle();
        check("t3_rr_p0_again", 64'({p1_grant, p0_grant}), 64'(1));
        advance();
        p0_cmd_en = 1'b0;
        read_beats(1'b0, 4, 64'hF200);
`else
        expect_cmd(1'b0, 4'd1, 1'b0);
        settle();
        check("t4_fixed_p0", 64'({p1_grant, p0_grant}), 64'(1));
        advance();
        p0_cmd_en = 1'b0;
        read_beats(1'b0, 4, 64'hF100);
        expect_cmd(1'b0, 4'd3, 1'b1);
        settle();
        check("t4_fixed_p1", 64'({p1_grant, p0_grant}), 64'(2));
        advance();
        p1_cmd_en = 1'b0;
        read_beats(1'b1, 4, 64'hF200);
`endif

        // Controller busy holds off the grant for 5 cycles.
        br_busy = 1'b1; p0_cmd = 1'b1; p0_addr = 4'd5; p0_cmd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("t5_no_grant", 64'({br_cmd_en, p0_grant}), 64'(0));
            advance();
        end
        br_busy = 1'b0;
        expect_cmd(1'b1, 4'd5, 1'b0);
        settle();
        check("t5_grant", 64'(p0_grant), 64'(1));
        advance();
        p0_cmd_en = 1'b0;
        tick(); tick(); tick();

        // Reset in the middle of a read burst.
        p0_cmd = 1'b0; p0_addr = 4'd6; p0_cmd_en = 1'b1;
        expect_cmd(1'b0, 4'd6, 1'b0);
        settle();
        check("t6_grant", 64'(p0_grant), 64'(1));
        advance();
        p0_cmd_en = 1'b0;
        read_beats(1'b0, 2, 64'hC000);
        rst = 1'b1; br_rd_data_ready = 1'b1;
        settle();
        check("t6_rst_ready", 64'(p0_rd_data_ready), 64'(0));
        advance();
        rst = 1'b0;
        settle();
        check("t6_late_ready", 64'(p0_rd_data_ready), 64'(0));
        check("t6_idle_busy", 64'({p1_busy, p0_busy}), 64'(0));
        advance();
        br_rd_data_ready = 1'b0;
        p1_cmd = 1'b0; p1_addr = 4'd9; p1_cmd_en = 1'b1;
        expect_cmd(1'b0, 4'd9, 1'b1);
        settle();
        check("t6_idle_grant", 64'(p1_grant), 64'(1));
        advance();
        p1_cmd_en = 1'b0;
        read_beats(1'b1, 4, 64'hC100);
        tick();

        check("sb_cmd_drained", 64'(cmd_q.size()), 64'(0));
        check("sb_rd_drained", 64'(rd_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
